// File: rtl/fem_stream_tx_if.sv
// Word stream from fem_stream_tx to the classifier/FIFO.
// master drives data and framing; slave drives out_ready.
interface fem_stream_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_FEATURES = 28
);
  localparam int IDX_W = $clog2(N_FEATURES + 1);

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sop;
  logic                  out_eop;
  logic [IDX_W-1:0]      out_idx;

  modport master (
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    input  out_idx,
    output out_ready
  );
endinterface

// File: rtl/fem_stream_tx.sv
// Serializes parallel feature vectors into a ready/valid word stream.
// Define FEM_TX_CHECKSUM_EN to append an XOR checksum beat per vector.
module fem_stream_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int N_FEATURES = 28,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_FEATURES-1:0][DATA_WIDTH-1:0] agg_features,
  input  logic                                  agg_valid,
  fem_stream_tx_if.master                       tx,
  output logic                                  busy,
  output logic [CNT_WIDTH-1:0]                  drop_cnt
);
  localparam int IDX_W = $clog2(N_FEATURES + 1);
  localparam int SEL_W = $clog2(N_FEATURES);

`ifdef FEM_TX_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FEATURES);
`else
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FEATURES - 1);
`endif

  typedef logic [N_FEATURES-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  vec_t                 active_q, active_d;
  vec_t                 pend_q, pend_d;
  logic                 pflag_q, pflag_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic                  send;
  logic                  last_acc;
  logic [DATA_WIDTH-1:0] word;

  assign send     = (state_q == SEND);
  assign last_acc = send && tx.out_ready && (idx_q == LAST);

`ifdef FEM_TX_CHECKSUM_EN
  // Checksum is a pure function of the captured vector.
  function automatic logic [DATA_WIDTH-1:0] xor_all(input vec_t v);
    logic [DATA_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_FEATURES; i++) begin
      acc = acc ^ v[i];
    end
    return acc;
  endfunction

  // Data word mux: feature words, then checksum on the final beat.
  always_comb begin
    word = '0;
    if (idx_q == LAST) word = xor_all(active_q);
    else               word = active_q[idx_q[SEL_W-1:0]];
  end
`else
  // Data word mux: current feature word.
  always_comb begin
    word = active_q[idx_q[SEL_W-1:0]];
  end
`endif

  // Stream outputs decoded from state and index.
  always_comb begin
    tx.out_valid = send;
    tx.out_data  = send ? word : '0;
    tx.out_idx   = idx_q;
    tx.out_sop   = send && (idx_q == '0);
    tx.out_eop   = send && (idx_q == LAST);
    busy         = send;
    drop_cnt     = drop_q;
  end

  // Next-state: capture, beat advance, pending hand-off, drops.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    drop_d   = drop_q;
    unique case (state_q)
      IDLE: begin
        if (agg_valid) begin
          active_d = agg_features;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (last_acc) begin
          idx_d = '0;
          if (pflag_q) begin
            active_d = pend_q;
            pflag_d  = 1'b0;
            if (agg_valid) begin
              pend_d  = agg_features;
              pflag_d = 1'b1;
            end
          end else if (agg_valid) begin
            active_d = agg_features;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (tx.out_ready) idx_d = idx_q + IDX_W'(1);
          if (agg_valid) begin
            if (!pflag_q) begin
              pend_d  = agg_features;
              pflag_d = 1'b1;
            end else if (drop_q != '1) begin
              drop_d = drop_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers; reset aborts any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      active_q <= '0;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      drop_q   <= drop_d;
    end
  end
endmodule

// File: doc/fem_stream_tx.md
Name: fem_stream_tx

Overview:
- Transmit-side counterpart of the feature extraction stage.
- Captures each parallel aggregated feature vector (`agg_features`/`agg_valid`) and serializes it into a ready/valid word stream for the downstream classifier/FIFO.
- One-deep pending buffer absorbs a second vector while the current one drains; further vectors are dropped and counted.

Parameters:
- DATA_WIDTH, 32, width of one feature word
- N_FEATURES, 28, words per feature vector (≥2)
- CNT_WIDTH, 16, width of the drop counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- agg_features  in  DATA_WIDTH x N_FEATURES  parallel feature vector
- agg_valid  in  1  single-cycle strobe, vector valid this cycle
- out_data  out  DATA_WIDTH  current stream word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word when out_valid && out_ready
- out_sop  out  1  first word of vector (idx 0)
- out_eop  out  1  last word of vector
- out_idx  out  $clog2(N_FEATURES+1)  index of current word
- busy  out  1  high in SEND state
- drop_cnt  out  CNT_WIDTH  vectors dropped, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; idx 0; pending flag clear; buffers 0. Asserting rst mid-vector aborts it immediately. No partial words follow reset release.
- Storage:
  - Active buffer: the vector being sent.
  - Pending buffer + pending flag.
- FSM states: IDLE, SEND.
- IDLE + agg_valid: load active buffer, idx←0, go SEND. out_valid rises the following cycle (latency 1 from agg_valid to first word).
- SEND:
  - out_valid=1.
  - out_data = active[idx].
  - out_sop = (idx==0).
  - out_eop = last beat.
  - Beat accepted: idx+1.
  - out_ready low: out_data/out_idx/out_sop/out_eop held stable; out_valid never drops mid-vector.
- SEND + agg_valid, not the last accepted beat:
  - Pending empty: copy to pending, set flag.
  - Pending full: discard, drop_cnt+1 (saturates at all-ones).
- Last beat accepted (idx == last):
  - Pending full: active←pending, clear flag, idx←0, stay SEND. Next word is sop back-to-back, no bubble. A simultaneous agg_valid loads into pending; no drop.
  - Pending empty, agg_valid same cycle: active←agg_features, idx←0, stay SEND.
  - Pending empty, no agg_valid: go IDLE, out_valid=0 next cycle.
- busy=1 exactly while in SEND.
- Captured vector contents are immune to later agg_features changes.
- Throughput: one word per cycle while out_ready=1. A vector of N words takes N accepted beats.

Optional Feature:
- Macro: FEM_TX_CHECKSUM_EN.
- Defined:
  - One extra beat appended after idx N_FEATURES-1, with out_idx=N_FEATURES.
  - out_data = XOR of all N_FEATURES words of the active vector, computed at capture or accumulated.
  - out_eop moves to the checksum beat; the "last beat" above refers to this beat.
- Undefined: no extra beat; eop on idx N_FEATURES-1; the checksum logic is absent.

Test Plan:
- N_FEATURES=4, out_ready=1, agg_valid once with words {1,2,3,4} -> out_valid from next cycle for 4 cycles. out_data 1,2,3,4; sop on 1, eop on 4; busy falls after; drop_cnt=0.
- Same vector, out_ready low on cycles 2–4 of stream -> words held stable while stalled. Sequence still 1,2,3,4, no duplicates or skips.
- Vector A={A0..A3} then B={B0..B3} 2 cycles later, out_ready=1 -> A streamed, then B immediately after A's eop with no idle cycle. drop_cnt=0.
- Vectors A, B, C on consecutive cycles while A streaming, out_ready=0 -> A then B streamed; C dropped; drop_cnt=1.
- agg_valid on the same cycle as A's last-beat acceptance, pending empty -> new vector starts the next cycle with sop, no bubble.
- rst asserted mid-vector (idx=2) -> out_valid=0 and busy=0 immediately; drop_cnt=0. The next agg_valid starts cleanly at idx 0.
- With FEM_TX_CHECKSUM_EN, vector {0x1,0x2,0x4,0x8} -> 5 beats; 5th beat out_data=0xF, out_idx=4, eop on 5th beat only.
